// File: rtl/echo_cm_display.sv
`default_nettype none
// ============================================================================
// Module      : echo_cm_display
// Description : Converts an ultrasonic echo high-time (in CLOCK_50 cycles)
//               into whole centimetres by repeated subtraction, then into
//               3-digit BCD by iterative double-dabble. Drives three
//               active-low 7-segment displays with leading-zero blanking and
//               a dash pattern for out-of-range results.
// Revision    : 1.0 - initial release
// ============================================================================
module echo_cm_display #(
    parameter int COUNT_W       = 21,
    parameter int CYCLES_PER_CM = 2900,
    parameter int MAX_CM        = 400
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [COUNT_W-1:0] echo_count,
    input  logic               echo_valid,
    output logic               echo_ready,
    output logic [8:0]         cm,
    output logic [11:0]        bcd,
    output logic               overrange,
    output logic               out_valid,
    output logic [6:0]         HEX0,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX2
);

    localparam logic [COUNT_W-1:0] CPC       = COUNT_W'(CYCLES_PER_CM);
    localparam logic [8:0]         MAX_Q     = 9'(MAX_CM);
    localparam logic [3:0]         ITERS     = 4'd9;
    localparam logic [6:0]         SEG_BLANK = 7'h7F;
    localparam logic [6:0]         SEG_DASH  = 7'b0111111;
    localparam logic [6:0]         SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVIDE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state_q;
    logic [COUNT_W-1:0] rem_q;
    logic [8:0]         quo_q;
    logic [20:0]        sh_q;        // {hundreds, tens, ones, binary}
    logic [20:0]        sh_adj;
    logic [20:0]        sh_d;
    logic [3:0]         iter_q;
    logic [8:0]         val_q;       // saturated binary value being converted
    logic               ovr_q;
    logic [8:0]         cm_q;
    logic [11:0]        bcd_q;
    logic               overrange_q;
    logic               out_valid_q;
    logic [6:0]         hex0_q, hex1_q, hex2_q;
    logic [6:0]         hex0_d, hex1_d, hex2_d;
    logic [3:0]         hund, tens, ones;

    // Double-dabble correction: a digit of 5 or more becomes >= 8 after +3,
    // so the following shift carries correctly into the next decade.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Active-low {g,f,e,d,c,b,a} patterns for decimal digits.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign hund = sh_q[20:17];
    assign tens = sh_q[16:13];
    assign ones = sh_q[12:9];

    // One double-dabble step: correct each BCD digit, then shift left by one.
    always_comb begin
        sh_adj = {add3(hund), add3(tens), add3(ones), sh_q[8:0]};
        sh_d   = 21'({sh_adj, 1'b0});
    end

    // Display patterns for the finished conversion, with leading-zero blanking.
    always_comb begin
        hex2_d = (hund == 4'd0) ? SEG_BLANK : seg7(hund);
        hex1_d = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg7(tens);
        hex0_d = seg7(ones);
        if (ovr_q) begin
            hex2_d = SEG_DASH;
            hex1_d = SEG_DASH;
            hex0_d = SEG_DASH;
        end
    end

    // Control FSM with divide/convert datapath and registered result outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            sh_q        <= '0;
            iter_q      <= '0;
            val_q       <= '0;
            ovr_q       <= 1'b0;
            cm_q        <= '0;
            bcd_q       <= '0;
            overrange_q <= 1'b0;
            out_valid_q <= 1'b0;
            hex0_q      <= SEG_ZERO;
            hex1_q      <= SEG_BLANK;
            hex2_q      <= SEG_BLANK;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (echo_valid) begin
                        rem_q   <= echo_count;
                        quo_q   <= '0;
                        state_q <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    // quo may pass MAX_CM by exactly one to flag overrange.
                    if (rem_q >= CPC && quo_q <= MAX_Q) begin
                        rem_q <= rem_q - CPC;
                        quo_q <= quo_q + 9'd1;
                    end else begin
                        val_q   <= (quo_q > MAX_Q) ? MAX_Q : quo_q;
                        sh_q    <= {12'd0, ((quo_q > MAX_Q) ? MAX_Q : quo_q)};
                        ovr_q   <= (quo_q > MAX_Q);
                        iter_q  <= '0;
                        state_q <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (iter_q != ITERS) begin
                        sh_q   <= sh_d;
                        iter_q <= iter_q + 4'd1;
                    end else begin
                        cm_q        <= val_q;
                        bcd_q       <= sh_q[20:9];
                        overrange_q <= ovr_q;
                        hex0_q      <= hex0_d;
                        hex1_q      <= hex1_d;
                        hex2_q      <= hex2_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign echo_ready = (state_q == IDLE) && !reset;
    assign cm         = cm_q;
    assign bcd        = bcd_q;
    assign overrange  = overrange_q;
    assign out_valid  = out_valid_q;
    assign HEX0       = hex0_q;
    assign HEX1       = hex1_q;
    assign HEX2       = hex2_q;

endmodule
`default_nettype wire

// File: tb/tb_echo_cm_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_echo_cm_display
// Description : Directed self-checking bench for echo_cm_display.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_echo_cm_display;

    localparam int COUNT_W = 21;

    logic               CLOCK_50 = 1'b0;
    logic               reset    = 1'b1;
    logic [COUNT_W-1:0] echo_count = '0;
    logic               echo_valid = 1'b0;
    logic               echo_ready;
    logic [8:0]         cm;
    logic [11:0]        bcd;
    logic               overrange;
    logic               out_valid;
    logic [6:0]         HEX0, HEX1, HEX2;

    int n_chk  = 0;
    int n_fail = 0;

    echo_cm_display #(
        .COUNT_W       (COUNT_W),
        .CYCLES_PER_CM (2900),
        .MAX_CM        (400)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .echo_count (echo_count),
        .echo_valid (echo_valid),
        .echo_ready (echo_ready),
        .cm         (cm),
        .bcd        (bcd),
        .overrange  (overrange),
        .out_valid  (out_valid),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!echo_ready && n < 1000) begin
            step();
            n++;
        end
        chk({tag, "_ready"}, 32'(echo_ready), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cm"},   32'(cm),        32'd0);
        chk({tag, "_bcd"},  32'(bcd),       32'd0);
        chk({tag, "_ovr"},  32'(overrange), 32'd0);
        chk({tag, "_ov"},   32'(out_valid), 32'd0);
        chk({tag, "_hex0"}, 32'(HEX0),      32'h40);
        chk({tag, "_hex1"}, 32'(HEX1),      32'h7F);
        chk({tag, "_hex2"}, 32'(HEX2),      32'h7F);
    endtask

    // One conversion: accept a count, measure latency, check all results.
    task automatic run_one(input string tag, input int count, input int lat,
                           input int ecm, input int ebcd, input int eovr,
                           input logic [6:0] h0, input logic [6:0] h1, input logic [6:0] h2);
        int n;
        wait_ready(tag);
        echo_count = COUNT_W'(count);
        echo_valid = 1'b1;
        step();
        echo_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 600) begin
            chk({tag, "_busy"}, 32'(echo_ready), 32'd0);
            step();
            n++;
        end
        chk({tag, "_lat"},  32'(n),         32'(lat));
        chk({tag, "_cm"},   32'(cm),        32'(ecm));
        chk({tag, "_bcd"},  32'(bcd),       32'(ebcd));
        chk({tag, "_ovr"},  32'(overrange), 32'(eovr));
        chk({tag, "_hex0"}, 32'(HEX0),      32'(h0));
        chk({tag, "_hex1"}, 32'(HEX1),      32'(h1));
        chk({tag, "_hex2"}, 32'(HEX2),      32'(h2));
        chk({tag, "_rdy_done"}, 32'(echo_ready), 32'd0);
        step();
        chk({tag, "_ov_pulse"}, 32'(out_valid), 32'd0);
        chk({tag, "_hold_cm"},  32'(cm),        32'(ecm));
        chk({tag, "_rdy_idle"}, 32'(echo_ready), 32'd1);
    endtask

    // echo_valid held high with a changing count; a small model predicts
    // which counts are accepted and when their results appear.
    task automatic hold_valid_test();
        int next_ready;
        int exp_valid;
        int exp_cm;
        int cnt;
        int q;
        next_ready = 0;
        exp_valid  = -1;
        exp_cm     = 0;
        for (int i = 0; i < 300; i++) begin
            chk("hold_ready", 32'(echo_ready), 32'(i >= next_ready));
            chk("hold_ov",    32'(out_valid),  32'(i == exp_valid));
            if (i == exp_valid) chk("hold_cm", 32'(cm), 32'(exp_cm));
            cnt = 2900 * ((i % 37) + 5) + 13;
            if (i < 299) begin
                echo_valid = 1'b1;
                echo_count = COUNT_W'(cnt);
                if (i >= next_ready) begin
                    q = cnt / 2900;
                    if (q > 401) q = 401;
                    exp_cm     = (q > 400) ? 400 : q;
                    exp_valid  = i + 1 + q + 11;
                    next_ready = i + 1 + q + 12;
                end
            end else begin
                echo_valid = 1'b0;
            end
            step();
        end
        echo_valid = 1'b0;
        wait_ready("hold_drain");
    endtask

    task automatic reset_mid_test();
        int seen;
        wait_ready("rmid");
        echo_count = COUNT_W'(290000);
        echo_valid = 1'b1;
        step();
        echo_valid = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        chk("rmid_rdy_in_rst", 32'(echo_ready), 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("rmid_rdy_after", 32'(echo_ready), 32'd1);
        check_reset_values("rmid");
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            if (out_valid) seen++;
            step();
        end
        chk("rmid_no_ov", 32'(seen), 32'd0);
        run_one("rmid_fresh", 29000, 21, 10, 12'h010, 0, 7'h40, 7'h79, 7'h7F);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        echo_valid = 1'b0;
        echo_count = '0;
        repeat (3) step();
        chk("rst_ready_low", 32'(echo_ready), 32'd0);
        chk("rst_ov_low",    32'(out_valid),  32'd0);
        reset = 1'b0;
        #1;
        chk("rst_ready_high", 32'(echo_ready), 32'd1);
        check_reset_values("rst");

        run_one("c29000",  29000,   21,  10,  12'h010, 0, 7'h40, 7'h79, 7'h7F);
        run_one("c359599", 359599,  134, 123, 12'h123, 0, 7'h30, 7'h24, 7'h79);
        run_one("c2899",   2899,    11,  0,   12'h000, 0, 7'h40, 7'h7F, 7'h7F);
        run_one("c0",      0,       11,  0,   12'h000, 0, 7'h40, 7'h7F, 7'h7F);
        run_one("c2900",   2900,    12,  1,   12'h001, 0, 7'h79, 7'h7F, 7'h7F);
        run_one("c168205", 168205,  69,  58,  12'h058, 0, 7'h00, 7'h12, 7'h7F);
        run_one("c400cm",  1160000, 411, 400, 12'h400, 0, 7'h40, 7'h40, 7'h19);
        hold_valid_test();
        run_one("c_ovr",   1200000, 412, 400, 12'h400, 1, 7'h3F, 7'h3F, 7'h3F);
        reset_mid_test();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
